ahb_slave_mux_n: RTL

- Parametrised AHB-Lite slave-to-master read/response multiplexer for NUM_SLAVES slaves.
- Registers the address-phase slave select and routes the selected slave's HRDATA/HREADYOUT/HRESP during the data phase.
- Adds an internal default slave: unselected NONSEQ/SEQ transfers get a two-cycle ERROR response.
- Adds a wait-state watchdog that aborts hung data phases with an ERROR response.
- Sits between the address decoder and the master, replacing the fixed three-slave multiplexer.

---
 rtl/ahb_slave_mux_n.sv | 86 ++++++++
 1 files changed

// File: rtl/ahb_slave_mux_n.sv
// ahb_slave_mux_n: AHB-Lite slave response multiplexer with a built-in default slave
// and a wait-state watchdog that turns a hung data phase into an ERROR response.
module ahb_slave_mux_n #(
    parameter int NUM_SLAVES = 4,
    parameter int DATA_WIDTH = 32,
    parameter int TIMEOUT    = 16,
    parameter int CNT_W      = 8
) (
    input  logic                             HCLK,
    input  logic                             HRESETn,
    input  logic [NUM_SLAVES-1:0]            HSEL,
    input  logic [1:0]                       HTRANS,
    input  logic [NUM_SLAVES*DATA_WIDTH-1:0] HRDATA_S,
    input  logic [NUM_SLAVES-1:0]            HREADYOUT_S,
    input  logic [NUM_SLAVES-1:0]            HRESP_S,
    output logic [DATA_WIDTH-1:0]            HRDATA,
    output logic                             HREADY,
    output logic                             HRESP,
    output logic                             sel_err,
    output logic                             timeout
);
    localparam int SEL_W = NUM_SLAVES > 1 ? $clog2(NUM_SLAVES) : 1;
    localparam logic [CNT_W-1:0] LAST_WAIT = CNT_W'(TIMEOUT - 1);

    typedef enum logic [1:0] {IDLE, SLAVE, ERR1, ERR2} state_t;

    state_t             state, state_n;
    logic [SEL_W-1:0]   sel_q, sel_n, low_idx;
    logic [CNT_W-1:0]   wcnt, wcnt_n;
    logic               sel_err_n, timeout_n, slave_rdy;

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            state   <= IDLE;
            sel_q   <= '0;
            wcnt    <= '0;
            sel_err <= 1'b0;
            timeout <= 1'b0;
        end else begin
            state   <= state_n;
            sel_q   <= sel_n;
            wcnt    <= wcnt_n;
            sel_err <= sel_err_n;
            timeout <= timeout_n;
        end
    end

    assign slave_rdy = HREADYOUT_S[sel_q];
    assign HREADY    = state == ERR1 ? 1'b0 : state == SLAVE ? slave_rdy : 1'b1;
    assign HRESP     = state == SLAVE ? HRESP_S[sel_q] : (state == ERR1 || state == ERR2);
    assign HRDATA    = state == SLAVE ? HRDATA_S[int'(sel_q)*DATA_WIDTH +: DATA_WIDTH] : '0;

    // Descending scan so the lowest set select wins on multi-hot HSEL.
    always_comb begin
        low_idx = '0;
        for (int i = NUM_SLAVES - 1; i >= 0; i--)
            if (HSEL[i]) low_idx = SEL_W'(i);
    end

    always_comb begin
        state_n   = state;
        sel_n     = sel_q;
        wcnt_n    = wcnt;
        sel_err_n = 1'b0;
        timeout_n = 1'b0;
        if (HREADY) begin
            if (HTRANS[1] && HSEL != '0) begin
                state_n   = SLAVE;
                sel_n     = low_idx;
                wcnt_n    = '0;
                sel_err_n = $countones(HSEL) > 1;
            end else begin
                state_n = HTRANS[1] ? ERR1 : IDLE;
            end
        end else if (state == ERR1) begin
            state_n = ERR2;
        end else if (TIMEOUT != 0 && wcnt == LAST_WAIT) begin
            // Only a stalled SLAVE data phase reaches here; abort it.
            state_n   = ERR1;
            wcnt_n    = '0;
            timeout_n = 1'b1;
        end else begin
            wcnt_n = wcnt + CNT_W'(wcnt != '1);
        end
    end
endmodule
